// File: rtl/pipe_seq_ctrl.sv
// Fetch/sequence controller: steps the PC, runs the three-cycle branch sequence,
// and moves between user code and the trap handler on interrupt entry and mret.
module pipe_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] MTVEC    = 32'd36
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        CONDITIONAL_JUMP,
    input  logic [31:0] JUMP_DEST,
    input  logic        INTERRUPT,
    input  logic        MRET,
    output logic [31:0] PC,
    output logic        DECODER_ENABLED,
    output logic        CPU_MODE,
    output logic [31:0] MEPC,
    output logic [2:0]  STATE
);

    localparam logic [2:0] S_RUN     = 3'd0;
    localparam logic [2:0] S_BR_EX   = 3'd1;
    localparam logic [2:0] S_BR_WB   = 3'd2;
    localparam logic [2:0] S_IRQ_D1  = 3'd3;
    localparam logic [2:0] S_IRQ_D2  = 3'd4;
    localparam logic [2:0] S_HANDLER = 3'd5;
    localparam logic [2:0] S_MR_D1   = 3'd6;
    localparam logic [2:0] S_MR_D2   = 3'd7;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        dec_en_q, dec_en_d;
    logic        mode_q, mode_d;
    logic [31:0] mepc_q, mepc_d;
    logic        ret_h_q, ret_h_d;

    // Requests are only sampled in RUN and HANDLER; a losing request is
    // simply seen again after the sequence because all inputs are levels.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        dec_en_d = dec_en_q;
        mode_d   = mode_q;
        mepc_d   = mepc_q;
        ret_h_d  = ret_h_q;
        case (state_q)
            S_RUN: begin
                if (CONDITIONAL_JUMP) begin
                    state_d  = S_BR_EX;
                    dec_en_d = 1'b0;
                    ret_h_d  = 1'b0;
                end else if (INTERRUPT) begin
                    state_d  = S_IRQ_D1;
                    mepc_d   = pc_q;
                    mode_d   = 1'b1;
                    dec_en_d = 1'b0;
                end else begin
                    pc_d = pc_q + 32'd1;
                end
            end
            // Target minus one, so the increment in BR_WB lands on JUMP_DEST.
            S_BR_EX: begin
                pc_d    = JUMP_DEST - 32'd1;
                state_d = S_BR_WB;
            end
            S_BR_WB: begin
                pc_d     = pc_q + 32'd1;
                dec_en_d = 1'b1;
                state_d  = ret_h_q ? S_HANDLER : S_RUN;
            end
            S_IRQ_D1: begin
                state_d = S_IRQ_D2;
            end
            S_IRQ_D2: begin
                pc_d     = MTVEC;
                dec_en_d = 1'b1;
                state_d  = S_HANDLER;
            end
            S_HANDLER: begin
                if (CONDITIONAL_JUMP) begin
                    state_d  = S_BR_EX;
                    dec_en_d = 1'b0;
                    ret_h_d  = 1'b1;
                end else if (MRET) begin
                    state_d  = S_MR_D1;
                    dec_en_d = 1'b0;
                end else begin
                    pc_d = pc_q + 32'd1;
                end
            end
            S_MR_D1: begin
                state_d = S_MR_D2;
            end
            S_MR_D2: begin
                pc_d     = mepc_q;
                mode_d   = 1'b0;
                dec_en_d = 1'b1;
                state_d  = S_RUN;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= S_RUN;
            pc_q     <= RESET_PC;
            dec_en_q <= 1'b1;
            mode_q   <= 1'b0;
            mepc_q   <= 32'd0;
            ret_h_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            dec_en_q <= dec_en_d;
            mode_q   <= mode_d;
            mepc_q   <= mepc_d;
            ret_h_q  <= ret_h_d;
        end
    end

    assign PC              = pc_q;
    assign DECODER_ENABLED = dec_en_q;
    assign CPU_MODE        = mode_q;
    assign MEPC            = mepc_q;
    assign STATE           = state_q;

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Bench for pipe_seq_ctrl: directed scenarios followed by random request traffic,
// all checked against a script-queue model of the observable sequence.
module tb_pipe_seq_ctrl;

    localparam logic [31:0] RESET_PC = 32'd0;
    localparam logic [31:0] MTVEC    = 32'd36;

    logic        clk;
    logic        rstn;
    logic        cj;
    logic [31:0] jd;
    logic        irq;
    logic        mret;
    logic [31:0] pc;
    logic        dec_en;
    logic        cpu_mode;
    logic [31:0] mepc;
    logic [2:0]  state;

    int n_checks = 0;
    int n_pass   = 0;

    pipe_seq_ctrl #(.RESET_PC(RESET_PC), .MTVEC(MTVEC)) dut (
        .CLK(clk),
        .RSTN(rstn),
        .CONDITIONAL_JUMP(cj),
        .JUMP_DEST(jd),
        .INTERRUPT(irq),
        .MRET(mret),
        .PC(pc),
        .DECODER_ENABLED(dec_en),
        .CPU_MODE(cpu_mode),
        .MEPC(mepc),
        .STATE(state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: one expected snapshot per cycle. A taken request pushes the whole
    // scripted sequence into exp_q; while it drains, requests are ignored.
    typedef struct {
        logic [2:0]  st;
        logic [31:0] pc;
        logic        de;
        logic        mode;
        logic [31:0] mepc;
    } snap_t;

    snap_t cur;
    snap_t exp_q[$];

    function automatic snap_t mk(input logic [2:0] st, input logic [31:0] p,
                                 input logic de, input logic md, input logic [31:0] ep);
        snap_t s;
        s.st = st; s.pc = p; s.de = de; s.mode = md; s.mepc = ep;
        return s;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        cur = mk(3'd0, RESET_PC, 1'b1, 1'b0, 32'd0);
    endtask

    // Predict the snapshot after the next rising edge, given the driven inputs.
    task automatic model_step(input logic c, input logic [31:0] d, input logic i, input logic m);
        logic [2:0] home;
        if (exp_q.size() == 0) begin
            home = cur.st;
            if (c) begin
                exp_q.push_back(mk(3'd1, cur.pc, 1'b0, cur.mode, cur.mepc));
                exp_q.push_back(mk(3'd2, d - 32'd1, 1'b0, cur.mode, cur.mepc));
                exp_q.push_back(mk(home, d, 1'b1, cur.mode, cur.mepc));
            end else if (home == 3'd0 && i) begin
                exp_q.push_back(mk(3'd3, cur.pc, 1'b0, 1'b1, cur.pc));
                exp_q.push_back(mk(3'd4, cur.pc, 1'b0, 1'b1, cur.pc));
                exp_q.push_back(mk(3'd5, MTVEC, 1'b1, 1'b1, cur.pc));
            end else if (home == 3'd5 && m) begin
                exp_q.push_back(mk(3'd6, cur.pc, 1'b0, 1'b1, cur.mepc));
                exp_q.push_back(mk(3'd7, cur.pc, 1'b0, 1'b1, cur.mepc));
                exp_q.push_back(mk(3'd0, cur.mepc, 1'b1, 1'b0, cur.mepc));
            end else begin
                cur.pc = cur.pc + 32'd1;
            end
        end
        if (exp_q.size() != 0) cur = exp_q.pop_front();
    endtask

    // scoreboard
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".state"}, {29'd0, state}, {29'd0, cur.st});
        check_eq({tag, ".pc"}, pc, cur.pc);
        check_eq({tag, ".dec_en"}, {31'd0, dec_en}, {31'd0, cur.de});
        check_eq({tag, ".mode"}, {31'd0, cpu_mode}, {31'd0, cur.mode});
        check_eq({tag, ".mepc"}, mepc, cur.mepc);
    endtask

    // driver tasks
    task automatic step(input string tag, input logic c, input logic [31:0] d,
                        input logic i, input logic m);
        cj = c; jd = d; irq = i; mret = m;
        model_step(c, d, i, m);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #1 rstn = 1'b0;
        model_reset();
        #1 check_all({tag, ".async"});
        @(negedge clk);
        rstn = 1'b1;
        check_all({tag, ".held"});
    endtask

    task automatic idle_until_pc(input logic [31:0] target);
        for (int k = 0; k < 64 && cur.pc != target; k++) step("idle", 1'b0, jd, 1'b0, 1'b0);
        check_eq("reach_pc", pc, target);
    endtask

    initial begin
        rstn = 1'b1; cj = 1'b0; jd = 32'd0; irq = 1'b0; mret = 1'b0;
        model_reset();

        // Reset, then linear run 0..5
        do_reset("reset");
        check_eq("reset.pc_const", pc, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            step("linear", 1'b0, 32'd0, 1'b0, 1'b0);
            check_eq("linear.pc_const", pc, k);
        end

        // Branch at PC=10 to 4
        idle_until_pc(32'd10);
        step("br1", 1'b1, 32'd4, 1'b0, 1'b0);
        check_eq("br1.const", {state, pc[7:0], 7'd0, dec_en}, {3'd1, 8'd10, 7'd0, 1'b0});
        step("br2", 1'b0, 32'd4, 1'b0, 1'b0);
        check_eq("br2.const", {state, pc[7:0], 7'd0, dec_en}, {3'd2, 8'd3, 7'd0, 1'b0});
        step("br3", 1'b0, 32'd4, 1'b0, 1'b0);
        check_eq("br3.const", {state, pc[7:0], 7'd0, dec_en}, {3'd0, 8'd4, 7'd0, 1'b1});
        step("br4", 1'b0, 32'd4, 1'b0, 1'b0);
        check_eq("br4.pc_const", pc, 32'd5);

        // Interrupt at PC=7, handler walks to 40, mret returns to 7
        idle_until_pc(32'd7);
        step("irq1", 1'b0, 32'd4, 1'b1, 1'b0);
        check_eq("irq1.mepc_const", mepc, 32'd7);
        step("irq2", 1'b0, 32'd4, 1'b1, 1'b0);
        step("irq3", 1'b0, 32'd4, 1'b1, 1'b0);
        check_eq("irq3.pc_const", pc, 32'd36);
        step("hnd1", 1'b0, 32'd4, 1'b1, 1'b0);
        check_eq("hnd1.pc_const", pc, 32'd37);
        idle_until_pc(32'd40);
        step("mr1", 1'b0, 32'd4, 1'b0, 1'b1);
        step("mr2", 1'b0, 32'd4, 1'b0, 1'b1);
        step("mr3", 1'b0, 32'd4, 1'b0, 1'b1);
        check_eq("mr3.const", {state, pc[7:0], 7'd0, cpu_mode}, {3'd0, 8'd7, 7'd0, 1'b0});

        // Branch and interrupt together: branch first, interrupt afterwards
        step("cj_irq1", 1'b1, 32'd100, 1'b1, 1'b0);
        step("cj_irq2", 1'b0, 32'd100, 1'b1, 1'b0);
        step("cj_irq3", 1'b0, 32'd100, 1'b1, 1'b0);
        step("cj_irq4", 1'b0, 32'd100, 1'b1, 1'b0);
        check_eq("cj_irq4.state_const", {29'd0, state}, 32'd3);
        step("cj_irq5", 1'b0, 32'd100, 1'b0, 1'b0);
        step("cj_irq6", 1'b0, 32'd100, 1'b0, 1'b0);

        // Branch and mret together in the handler: branch wins, back to HANDLER
        step("cj_mr1", 1'b1, 32'd50, 1'b0, 1'b1);
        step("cj_mr2", 1'b0, 32'd50, 1'b0, 1'b1);
        step("cj_mr3", 1'b0, 32'd50, 1'b0, 1'b0);
        check_eq("cj_mr3.const", {state, pc[7:0]}, {3'd5, 8'd50});
        for (int k = 0; k < 3; k++) step("mr_back", 1'b0, 32'd50, 1'b0, 1'b1);
        check_eq("mr_back.pc_const", pc, 32'd100);

        // Wraparound: jump to 0, then to 0xFFFFFFFF and step past it
        for (int k = 0; k < 3; k++) step("wrap0", k == 0, 32'd0, 1'b0, 1'b0);
        check_eq("wrap0.pc_const", pc, 32'd0);
        for (int k = 0; k < 4; k++) step("wrapf", k == 0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check_eq("wrapf.pc_const", pc, 32'd0);

        // Reset pulsed in IRQ_D2
        step("rst_irq1", 1'b0, 32'd0, 1'b1, 1'b0);
        step("rst_irq2", 1'b0, 32'd0, 1'b0, 1'b0);
        check_eq("rst_irq.in_d2", {29'd0, state}, 32'd4);
        do_reset("rst_irq");
        check_eq("rst_irq.const", {state, pc[7:0], 7'd0, cpu_mode}, 19'd0);

        // Random traffic; JUMP_DEST only changes while no sequence is running
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset("rnd_reset");
            end else begin
                logic [31:0] d;
                d = (exp_q.size() == 0) ? $urandom : jd;
                step("rnd", $urandom_range(0, 4) == 0, d,
                     $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
